// File: rtl/seq_mult16_pkg.sv
// Shared definitions for the seq_mult16 shift-add multiplier:
// state encodings, default operand width and the iteration counter width.
package seq_mult16_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  localparam int unsigned DEF_WIDTH = 16;

  // Counter must hold the value WIDTH itself, hence WIDTH+1.
  function automatic int unsigned cnt_width(input int unsigned w);
    return $clog2(w + 1);
  endfunction

endpackage

// File: rtl/seq_mult16_datapath.sv
// Shift-add datapath for seq_mult16: multiplicand, multiplier, accumulator
// and iteration counter, sequenced by load/step strobes from the top FSM.
module mult_datapath
  import seq_mult16_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_i,
  input  logic               step_i,
  input  logic [WIDTH-1:0]   a_i,
  input  logic [WIDTH-1:0]   b_i,
  output logic               last_o,
  output logic [2*WIDTH-1:0] acc_next_o
);

  localparam int unsigned CW = cnt_width(WIDTH);

  logic [2*WIDTH-1:0] mcand_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [CW-1:0]      count_q;

  // acc_next_o is also the final product on the last iteration.
  assign acc_next_o = mplier_q[0] ? (acc_q + mcand_q) : acc_q;
  assign last_o     = (count_q == CW'(1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      count_q  <= '0;
    end else if (load_i) begin
      mcand_q  <= {{WIDTH{1'b0}}, a_i};
      acc_q    <= '0;
      mplier_q <= b_i;
      count_q  <= CW'(WIDTH);
    end else if (step_i) begin
      acc_q    <= acc_next_o;
      mcand_q  <= mcand_q << 1;
      mplier_q <= mplier_q >> 1;
      count_q  <= count_q - CW'(1);
    end
  end

endmodule

// File: rtl/seq_mult16.sv
// Multicycle unsigned shift-add multiplier: fixed WIDTH-iteration latency,
// one-cycle done pulse, product held until the next completion.
module seq_mult16
  import seq_mult16_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic               busy,
  output logic               done,
  output logic [2*WIDTH-1:0] product
);

  state_e             state_q, state_d;
  logic               busy_q, done_q;
  logic [2*WIDTH-1:0] product_q;
  logic               load, step, last;
  logic [2*WIDTH-1:0] acc_next;

  mult_datapath #(.WIDTH(WIDTH)) u_dp (
    .clk        (clk),
    .reset      (reset),
    .load_i     (load),
    .step_i     (step),
    .a_i        (a),
    .b_i        (b),
    .last_o     (last),
    .acc_next_o (acc_next)
  );

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    step    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          load    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        step = 1'b1;
        if (last) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // busy/done come from flops loaded with the next state, not decoded combinationally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      product_q <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= (state_d == ST_RUN) || (state_d == ST_DONE);
      done_q  <= (state_d == ST_DONE);
      if (state_q == ST_RUN && last) product_q <= acc_next;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign product = product_q;

endmodule

// File: tb/tb_seq_mult16.sv
// Self-checking bench for seq_mult16: timing-rule reference model checked
// every cycle, directed literal cases, downstream register, random traffic.
module tb_seq_mult16;

  localparam int W = 16;

  logic          clk;
  logic          reset;
  logic          start;
  logic [W-1:0]  a, b;
  logic          busy, done;
  logic [31:0]   product;
  logic          reg_rst;
  logic [31:0]   r32;

  int n_chk  = 0;
  int n_fail = 0;

  seq_mult16 #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .a       (a),
    .b       (b),
    .busy    (busy),
    .done    (done),
    .product (product)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream load-enabled register fed by done/product.
  always @(posedge clk) begin
    if (reg_rst) r32 <= 32'h0;
    else if (done) r32 <= product;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: an accepted op at edge e0 is busy through e0+W,
  // completes at e0+W, and the next accept may happen at e0+W+2 or later.
  int          cyc   = 0;
  int          e0    = -1000;
  bit          in_op = 1'b0;
  logic [31:0] m_res = 32'h0;
  logic [31:0] m_prod = 32'h0;

  always @(negedge reset) begin
    in_op  = 1'b0;
    m_prod = 32'h0;
  end

  always @(posedge clk) begin
    cyc++;
    if (!reset) begin
      in_op  = 1'b0;
      m_prod = 32'h0;
    end else begin
      if ((!in_op || cyc > e0 + W + 1) && start) begin
        in_op = 1'b1;
        e0    = cyc;
        m_res = 32'(a) * 32'(b);
      end
      if (in_op && cyc == e0 + W) m_prod = m_res;
    end
    #1;
    chk("model_busy", {31'b0, busy}, {31'b0, (in_op && cyc >= e0 && cyc <= e0 + W)});
    chk("model_done", {31'b0, done}, {31'b0, (in_op && cyc == e0 + W)});
    chk("model_product", product, m_prod);
  end

  // Drives an op from the current negedge; returns at the negedge after E0+W+1.
  task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic [31:0] exp, input logic [31:0] prev);
    a = av; b = bv; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("op_busy_after_accept", {31'b0, busy}, 32'd1);
    a = 16'($urandom); b = 16'($urandom);
    repeat (W - 1) @(negedge clk);
    chk("op_done_early", {31'b0, done}, 32'd0);
    chk("op_product_held", product, prev);
    @(negedge clk);
    chk("op_done", {31'b0, done}, 32'd1);
    chk("op_product", product, exp);
    @(negedge clk);
    chk("op_done_fall", {31'b0, done}, 32'd0);
    chk("op_busy_fall", {31'b0, busy}, 32'd0);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 5))
      0:       return '0;
      1:       return '1;
      default: return 16'($urandom);
    endcase
  endfunction

  initial begin
    reset = 1'b0; start = 1'b0; a = '0; b = '0; reg_rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_product", product, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    run_op(16'd3, 16'd5, 32'h0000000F, 32'h0);
    run_op(16'hFFFF, 16'hFFFF, 32'hFFFE0001, 32'h0000000F);
    run_op(16'h0000, 16'h1234, 32'h0, 32'hFFFE0001);

    // start re-asserted through RUN and DONE is ignored, then accepted in IDLE
    a = 16'd7; b = 16'd6; start = 1'b1;
    @(negedge clk);
    a = 16'd9; b = 16'd9;
    repeat (W) @(negedge clk);
    chk("b2b_first_done", {31'b0, done}, 32'd1);
    chk("b2b_first_product", product, 32'h0000002A);
    @(negedge clk);
    chk("b2b_idle_busy", {31'b0, busy}, 32'd0);
    @(negedge clk);
    start = 1'b0;
    chk("b2b_second_busy", {31'b0, busy}, 32'd1);
    repeat (W) @(negedge clk);
    chk("b2b_second_done", {31'b0, done}, 32'd1);
    chk("b2b_second_product", product, 32'h00000051);
    @(negedge clk);

    // asynchronous reset mid-operation, away from any clock edge
    a = 16'd100; b = 16'd200; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    chk("midreset_busy", {31'b0, busy}, 32'd0);
    chk("midreset_done", {31'b0, done}, 32'd0);
    chk("midreset_product", product, 32'h0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    run_op(16'd2, 16'd2, 32'h00000004, 32'h0);

    // downstream register: held in reset, then loads only on done
    run_op(16'd5, 16'd5, 32'd25, 32'd4);
    chk("reg_in_reset", r32, 32'h0);
    reg_rst = 1'b0;
    run_op(16'd3, 16'd5, 32'd15, 32'd25);
    chk("reg_loaded_15", r32, 32'd15);
    a = 16'd10; b = 16'd10; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    chk("reg_hold_mid_run", r32, 32'd15);
    repeat (8) @(negedge clk);
    chk("reg_hold_at_done", r32, 32'd15);
    @(negedge clk);
    chk("reg_loaded_100", r32, 32'd100);

    // random traffic, checked by the model every cycle
    repeat (600) begin
      @(negedge clk);
      start = ($urandom_range(0, 2) == 0);
      a = pick();
      b = pick();
    end
    start = 1'b0;
    repeat (W + 4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
